// File: rtl/membank_serializer.sv
// Four-bank x 16-word x 16-bit memory with a bit-serial read-out engine.
// Reads shift MSB first on membitclk edges; writes commit on epc_data_ready edges.
module membank_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_read,
  input  logic        epc_mode,
  input  logic [1:0]  readwritebank,
  input  logic [7:0]  readwriteptr,
  input  logic [7:0]  readwords,
  input  logic [15:0] writedataout,
  input  logic        epc_data_ready,
  input  logic        abort,
  input  logic        membitclk,
  output logic        membitsrc,
  output logic        memdatadone,
  output logic        busy,
  output logic        range_err,
  output logic        write_ack
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state;
  logic [15:0] mem [64];
  logic        bitclk_q;
  logic        wrrdy_q;
  logic        bit_edge;
  logic        wr_edge;
  logic        wr_ok;
  logic [1:0]  bank;
  logic [3:0]  ptr;
  logic [3:0]  next_ptr;
  logic [4:0]  words_left;
  logic [3:0]  bitcnt;
  logic [15:0] shreg;
  logic [8:0]  req_count;
  logic [8:0]  req_end;
  logic        req_bad;

  assign bit_edge  = membitclk & ~bitclk_q;
  assign wr_edge   = epc_data_ready & ~wrrdy_q;
  assign wr_ok     = wr_edge && (readwriteptr <= 8'd15);
  assign next_ptr  = ptr + 4'd1;
  assign membitsrc = (state == SHIFT) & shreg[15];

  // A zero word count means "through the last word of the bank".
  always_comb begin
    req_count = (readwords == 8'd0) ? (9'd16 - {1'b0, readwriteptr}) : {1'b0, readwords};
    req_end   = {1'b0, readwriteptr} + req_count;
    req_bad   = (readwriteptr > 8'd15) || (req_end > 9'd16);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bitclk_q <= 1'b0;
      wrrdy_q  <= 1'b0;
    end else begin
      bitclk_q <= membitclk;
      wrrdy_q  <= epc_data_ready;
    end
  end

  // Bank1 word0 powers up holding 16'h3000; everything else clears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 16) ? 16'h3000 : 16'h0000;
      write_ack <= 1'b0;
    end else begin
      write_ack <= wr_ok;
      if (wr_ok) mem[{readwritebank, readwriteptr[3:0]}] <= writedataout;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      memdatadone <= 1'b0;
      busy        <= 1'b0;
      range_err   <= 1'b0;
      bitcnt      <= 4'd0;
      shreg       <= 16'h0000;
      bank        <= 2'd0;
      ptr         <= 4'd0;
      words_left  <= 5'd0;
    end else if (abort) begin
      state       <= IDLE;
      memdatadone <= 1'b0;
      busy        <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_read) begin
            memdatadone <= 1'b0;
            range_err   <= 1'b0;
            if (epc_mode) begin
              bank       <= 2'd1;
              ptr        <= 4'd1;
              words_left <= 5'd7;
              busy       <= 1'b1;
              state      <= LOAD;
            end else if (req_bad) begin
              range_err   <= 1'b1;
              memdatadone <= 1'b1;
              state       <= DONE;
            end else begin
              bank       <= readwritebank;
              ptr        <= readwriteptr[3:0];
              words_left <= req_count[4:0];
              busy       <= 1'b1;
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          shreg  <= mem[{bank, ptr}];
          bitcnt <= 4'd0;
          state  <= SHIFT;
        end
        SHIFT: begin
          // The next word is fetched on the last bit's edge so the stream has no gap.
          if (bit_edge) begin
            if (bitcnt == 4'd15) begin
              bitcnt <= 4'd0;
              if (words_left > 5'd1) begin
                ptr        <= next_ptr;
                shreg      <= mem[{bank, next_ptr}];
                words_left <= words_left - 5'd1;
              end else begin
                shreg       <= {shreg[14:0], 1'b0};
                memdatadone <= 1'b1;
                busy        <= 1'b0;
                state       <= DONE;
              end
            end else begin
              shreg  <= {shreg[14:0], 1'b0};
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_membank_serializer.sv
// Scoreboard bench for membank_serializer: expected bits are queued from a
// shadow memory when a read is requested and popped as each bit is clocked out.
module tb_membank_serializer;

  logic        clk;
  logic        reset;
  logic        start_read;
  logic        epc_mode;
  logic [1:0]  readwritebank;
  logic [7:0]  readwriteptr;
  logic [7:0]  readwords;
  logic [15:0] writedataout;
  logic        epc_data_ready;
  logic        abort;
  logic        membitclk;
  logic        membitsrc;
  logic        memdatadone;
  logic        busy;
  logic        range_err;
  logic        write_ack;

  logic [15:0] model_mem [64];
  logic        exp_q [$];
  int          checks_total;
  int          checks_passed;

  membank_serializer dut (
    .clk            (clk),
    .reset          (reset),
    .start_read     (start_read),
    .epc_mode       (epc_mode),
    .readwritebank  (readwritebank),
    .readwriteptr   (readwriteptr),
    .readwords      (readwords),
    .writedataout   (writedataout),
    .epc_data_ready (epc_data_ready),
    .abort          (abort),
    .membitclk      (membitclk),
    .membitsrc      (membitsrc),
    .memdatadone    (memdatadone),
    .busy           (busy),
    .range_err      (range_err),
    .write_ack      (write_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_mem[i] = (i == 16) ? 16'h3000 : 16'h0000;
  endtask

  task automatic do_write(input logic [1:0] b, input logic [7:0] p, input logic [15:0] d);
    readwritebank  = b;
    readwriteptr   = p;
    writedataout   = d;
    epc_data_ready = 1'b1;
    @(negedge clk);
    checkOutput("write_ack", {31'd0, write_ack}, {31'd0, (p <= 8'd15)});
    epc_data_ready = 1'b0;
    @(negedge clk);
    checkOutput("write_ack_pulse", {31'd0, write_ack}, 32'd0);
    if (p <= 8'd15) model_mem[b * 16 + int'(p[3:0])] = d;
  endtask

  // Queues the model's bits for the request, then pulses start_read.
  task automatic applyStimulus(input logic epc, input logic [1:0] b, input logic [7:0] p, input logic [7:0] n);
    int rb, rp, cnt;
    logic [15:0] w;
    if (epc) begin
      rb = 1; rp = 1; cnt = 7;
    end else begin
      rb = int'(b); rp = int'(p);
      cnt = (n == 8'd0) ? 16 - rp : int'(n);
    end
    if (!(rp > 15 || rp + cnt > 16)) begin
      for (int k = 0; k < cnt; k++) begin
        w = model_mem[rb * 16 + rp + k];
        for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
      end
    end
    epc_mode      = epc;
    readwritebank = b;
    readwriteptr  = p;
    readwords     = n;
    start_read    = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic shift_bit();
    logic b;
    b = membitsrc;
    if (exp_q.size() > 0) checkOutput("bit", {31'd0, b}, {31'd0, exp_q.pop_front()});
    else checkOutput("idle_bit", {31'd0, b}, 32'd0);
    membitclk = 1'b1;
    @(negedge clk);
    membitclk = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      checkOutput("busy", {31'd0, busy}, 32'd1);
      checkOutput("done_low", {31'd0, memdatadone}, 32'd0);
      shift_bit();
    end
    checkOutput("done", {31'd0, memdatadone}, 32'd1);
    checkOutput("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_membitsrc"}, {31'd0, membitsrc}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, memdatadone}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_range_err"}, {31'd0, range_err}, 32'd0);
    checkOutput({tag, "_write_ack"}, {31'd0, write_ack}, 32'd0);
  endtask

  initial begin
    logic [15:0] old_w, new_w;
    checks_total   = 0;
    checks_passed  = 0;
    reset          = 1'b0;
    start_read     = 1'b0;
    epc_mode       = 1'b0;
    readwritebank  = 2'd0;
    readwriteptr   = 8'd0;
    readwords      = 8'd0;
    writedataout   = 16'h0;
    epc_data_ready = 1'b0;
    abort          = 1'b0;
    membitclk      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] write A5C3 and read it back, with an ignored start mid-read");
    do_write(2'd3, 8'd2, 16'hA5C3);
    applyStimulus(1'b0, 2'd3, 8'd2, 8'd1);
    repeat (4) shift_bit();
    epc_mode   = 1'b1;
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    drain();

    $display("[TB] EPC reply of bank1 words 1..7");
    for (int i = 1; i <= 7; i++) do_write(2'd1, 8'(i), 16'($urandom));
    applyStimulus(1'b1, 2'd2, 8'd9, 8'd3);
    drain();

    $display("[TB] bank2 ptr14 count0");
    do_write(2'd2, 8'd14, 16'($urandom));
    do_write(2'd2, 8'd15, 16'($urandom));
    applyStimulus(1'b0, 2'd2, 8'd14, 8'd0);
    drain();
    shift_bit();

    $display("[TB] out of range request");
    applyStimulus(1'b0, 2'd0, 8'd15, 8'd2);
    checkOutput("range_err", {31'd0, range_err}, 32'd1);
    checkOutput("range_done", {31'd0, memdatadone}, 32'd1);
    checkOutput("range_busy", {31'd0, busy}, 32'd0);
    shift_bit();

    $display("[TB] abort after 20 edges of a 3-word read");
    for (int i = 0; i < 3; i++) do_write(2'd0, 8'(i), 16'($urandom));
    applyStimulus(1'b0, 2'd0, 8'd0, 8'd3);
    checkOutput("start_clears_range_err", {31'd0, range_err}, 32'd0);
    repeat (20) shift_bit();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    check_quiet("abort");
    repeat (3) shift_bit();
    abort      = 1'b1;
    start_read = 1'b1;
    @(negedge clk);
    abort      = 1'b0;
    start_read = 1'b0;
    @(negedge clk);
    checkOutput("abort_over_start", {31'd0, busy}, 32'd0);

    $display("[TB] out-of-range write and LOAD/write collision");
    do_write(2'd0, 8'h12, 16'hDEAD);
    applyStimulus(1'b0, 2'd0, 8'd2, 8'd1);
    drain();
    old_w = model_mem[5];
    new_w = ~old_w ^ 16'h1234;
    for (int i = 15; i >= 0; i--) exp_q.push_back(old_w[i]);
    epc_mode      = 1'b0;
    readwritebank = 2'd0;
    readwriteptr  = 8'd5;
    readwords     = 8'd1;
    writedataout  = new_w;
    start_read    = 1'b1;
    @(negedge clk);
    start_read     = 1'b0;
    epc_data_ready = 1'b1;
    @(negedge clk);
    epc_data_ready = 1'b0;
    checkOutput("collision_ack", {31'd0, write_ack}, 32'd1);
    model_mem[5] = new_w;
    drain();
    applyStimulus(1'b0, 2'd0, 8'd5, 8'd1);
    drain();

    $display("[TB] reset during shift");
    applyStimulus(1'b0, 2'd1, 8'd1, 8'd4);
    repeat (5) shift_bit();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_quiet("midreset");
    shift_bit();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    applyStimulus(1'b0, 2'd1, 8'd0, 8'd1);
    drain();
    applyStimulus(1'b0, 2'd3, 8'd2, 8'd1);
    drain();
    applyStimulus(1'b0, 2'd1, 8'd1, 8'd0);
    drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
